// File: rtl/aes_pkg.sv
// Shared types and constants for the AES block writer.
package aes_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned ROW_W           = 32;

  typedef logic [ROW_W-1:0] row_t;
  typedef row_t [WORDS_PER_BLOCK-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FULL
  } state_t;

endpackage

// File: rtl/aes_block_writer_if.sv
// Block-input handshake and output-memory write bus of the AES block writer.
interface aes_block_writer_if
  import aes_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
);

  logic              in_valid;
  logic              in_ready;
  row_t              in_row0;
  row_t              in_row1;
  row_t              in_row2;
  row_t              in_row3;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  row_t              mem_wdata;

  // AES core / environment side: offers blocks, observes the memory writes.
  modport master (
    output in_valid,
    output in_row0,
    output in_row1,
    output in_row2,
    output in_row3,
    input  in_ready,
    input  mem_wen,
    input  mem_addr,
    input  mem_wdata
  );

  // Writer side: accepts blocks, drives the memory writes.
  modport slave (
    input  in_valid,
    input  in_row0,
    input  in_row1,
    input  in_row2,
    input  in_row3,
    output in_ready,
    output mem_wen,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/aes_block_writer.sv
// Serializes 128-bit AES result blocks (four 32-bit rows) into a word-addressed
// output memory, one word per cycle, with a sticky full state once the memory
// has been written up to its last word.
module aes_block_writer
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  aes_block_writer_if.slave bus,
  output logic [ADDR_W-2:0] block_count,
  output logic              full
);

  localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-2:0]  count_q, count_d;
  block_t             rows_q, rows_d;

  logic last_word;
  logic last_addr;
  logic ready;
  logic accept;

  assign last_word = (idx_q == IDX_W'(WORDS_PER_BLOCK - 1));
  assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));

  // A new block may only enter when the current one is finishing and there is room after it.
  assign ready  = (state_q == IDLE) || ((state_q == WRITE) && last_word && !last_addr);
  assign accept = bus.in_valid && ready;

  // State register; reset takes priority over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      rows_q  <= rows_d;
    end
  end

  // Next-state logic: latch on accept, step one word per cycle while writing.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    count_d = count_q;
    rows_d  = rows_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rows_d  = {bus.in_row3, bus.in_row2, bus.in_row1, bus.in_row0};
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d = addr_q + 1'b1;
        idx_d  = idx_q + 1'b1;
        if (last_word) begin
          count_d = count_q + 1'b1;
          if (last_addr) begin
            state_d = FULL;
          end else if (accept) begin
            rows_d  = {bus.in_row3, bus.in_row2, bus.in_row1, bus.in_row0};
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FULL: begin
        state_d = FULL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come from registered state only.
  assign bus.in_ready  = ready;
  assign bus.mem_wen   = (state_q == WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = rows_q[idx_q];
  assign block_count   = count_q;
  assign full          = (state_q == FULL);

endmodule

// File: tb/tb_aes_block_writer.sv
// Bench for aes_block_writer: scoreboarded write checking on a full-size
// instance plus a hand-driven fill-to-full sequence on an 8-word instance.
module tb_aes_block_writer;
  import aes_pkg::*;

  localparam int unsigned BIG_DEPTH   = 1024;
  localparam int unsigned BIG_AW      = 10;
  localparam int unsigned SMALL_DEPTH = 8;
  localparam int unsigned SMALL_AW    = 3;

  typedef struct packed {
    logic [BIG_AW-1:0] addr;
    row_t              data;
  } wr_t;

  typedef struct {
    row_t        r0;
    row_t        r1;
    row_t        r2;
    row_t        r3;
    bit          chain;
    int unsigned exp_count;
    int unsigned exp_run;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [BIG_AW-2:0]   big_count;
  logic                big_full;
  logic [SMALL_AW-2:0] small_count;
  logic                small_full;

  aes_block_writer_if #(.ADDR_W(BIG_AW))   bf ();
  aes_block_writer_if #(.ADDR_W(SMALL_AW)) sf ();

  aes_block_writer #(.DEPTH(BIG_DEPTH), .ADDR_W(BIG_AW)) u_big (
    .clk         (clk),
    .rst         (rst),
    .bus         (bf),
    .block_count (big_count),
    .full        (big_full)
  );

  aes_block_writer #(.DEPTH(SMALL_DEPTH), .ADDR_W(SMALL_AW)) u_small (
    .clk         (clk),
    .rst         (rst),
    .bus         (sf),
    .block_count (small_count),
    .full        (small_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for the big instance: push on handshake, pop on every write.
  wr_t               sb[$];
  logic [BIG_AW-1:0] exp_addr = '0;
  int                run = 0;
  int                last_run = 0;

  always @(negedge clk) begin
    if (bf.mem_wen === 1'b1) begin
      run++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                 bf.mem_addr, bf.mem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(bf.mem_addr), 64'(e.addr));
        check("wr_data", 64'(bf.mem_wdata), 64'(e.data));
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (rst === 1'b1) begin
      sb.delete();
      exp_addr = '0;
    end else if (bf.in_valid === 1'b1 && bf.in_ready === 1'b1) begin
      sb.push_back('{addr: exp_addr,                 data: bf.in_row0});
      sb.push_back('{addr: exp_addr + BIG_AW'(1), data: bf.in_row1});
      sb.push_back('{addr: exp_addr + BIG_AW'(2), data: bf.in_row2});
      sb.push_back('{addr: exp_addr + BIG_AW'(3), data: bf.in_row3});
      exp_addr = exp_addr + BIG_AW'(4);
    end
  end

  // Offer one block to the big instance and hold it until accepted (bounded).
  task automatic send_big(input row_t r0, input row_t r1, input row_t r2, input row_t r3);
    bit acc = 1'b0;
    bf.in_valid = 1'b1;
    bf.in_row0  = r0;
    bf.in_row1  = r1;
    bf.in_row2  = r2;
    bf.in_row3  = r3;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = (bf.in_ready === 1'b1) && !rst;
      @(posedge clk);
      #1;
    end
    bf.in_valid = 1'b0;
    check("accept", 64'(acc), 64'(1));
  endtask

  // Wait until the big instance stops writing, then step to just after the next edge.
  task automatic drain_big();
    int n = 0;
    @(negedge clk);
    while (bf.mem_wen === 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(bf.mem_wen), 64'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic row_t small_row(input int b, input int r);
    return {8'(b), 8'(r), 16'hC0DE};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    logic [SMALL_AW-1:0] s_addr[$];
    row_t                s_data[$];
    int                  w7_cyc;
    int                  full_cyc;
    int                  blk;
    bit                  acc;

    vecs[0] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 1'b1, 0, 0};
    vecs[1] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b1, 0, 0};
    vecs[2] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFF0000, 32'h0000FFFF, 1'b0, 4, 12};
    vecs[3] = '{32'h00000001, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, 5, 4};
    vecs[4] = '{32'hCAFEF00D, 32'hBAADC0DE, 32'h0BADBEEF, 32'h12345678, 1'b1, 0, 0};
    vecs[5] = '{32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b0, 7, 8};

    // Reset with a block already offered: it must not be taken.
    rst         = 1'b1;
    bf.in_valid = 1'b1;
    bf.in_row0  = 32'hBADBAD00;
    bf.in_row1  = 32'hBADBAD01;
    bf.in_row2  = 32'hBADBAD02;
    bf.in_row3  = 32'hBADBAD03;
    sf.in_valid = 1'b0;
    sf.in_row0  = '0;
    sf.in_row1  = '0;
    sf.in_row2  = '0;
    sf.in_row3  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst         = 1'b0;
    bf.in_valid = 1'b0;
    @(negedge clk);
    check("rst_wen",   64'(bf.mem_wen),   64'(0));
    check("rst_addr",  64'(bf.mem_addr),  64'(0));
    check("rst_wdata", 64'(bf.mem_wdata), 64'(0));
    check("rst_count", 64'(big_count),    64'(0));
    check("rst_full",  64'(big_full),     64'(0));
    check("rst_ready", 64'(bf.in_ready),  64'(1));
    @(posedge clk);
    #1;

    // Single block: four write cycles, then back to idle with one block counted.
    send_big(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      check("single_wen", 64'(bf.mem_wen), 64'(1));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("single_idle_wen", 64'(bf.mem_wen),  64'(0));
    check("single_count",    64'(big_count),   64'(1));
    check("single_ready",    64'(bf.in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Table: chained entries go back-to-back, others drain and check count/streak.
    for (int i = 0; i < 6; i++) begin
      send_big(vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].r3);
      if (!vecs[i].chain) begin
        drain_big();
        check("vec_count", 64'(big_count), 64'(vecs[i].exp_count));
        check("vec_run",   64'(last_run),  64'(vecs[i].exp_run));
        check("vec_ready", 64'(bf.in_ready), 64'(1));
      end
    end

    // Backpressure: next block waits until the last-word cycle; rows change meanwhile.
    send_big(32'hAAAA0000, 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003);
    bf.in_valid = 1'b1;
    bf.in_row0  = 32'hBBBB0000;
    bf.in_row1  = 32'hBBBB0001;
    bf.in_row2  = 32'hBBBB0002;
    bf.in_row3  = 32'hBBBB0003;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(bf.in_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("bp_ready_last", 64'(bf.in_ready), 64'(1));
    @(posedge clk);
    #1;
    bf.in_valid = 1'b0;
    drain_big();
    check("bp_count", 64'(big_count), 64'(9));
    check("bp_run",   64'(last_run),  64'(8));

    // Reset two words into a block: abandon it and restart from word 0.
    send_big(32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_wen",   64'(bf.mem_wen),  64'(0));
    check("mid_rst_addr",  64'(bf.mem_addr), 64'(0));
    check("mid_rst_count", 64'(big_count),   64'(0));
    check("mid_rst_ready", 64'(bf.in_ready), 64'(1));
    @(posedge clk);
    #1;
    send_big(32'h0D0D0000, 32'h0D0D0001, 32'h0D0D0002, 32'h0D0D0003);
    drain_big();
    check("post_rst_count", 64'(big_count), 64'(1));

    // Small instance: keep offering blocks until it fills after two.
    w7_cyc   = -1;
    full_cyc = -1;
    blk      = 0;
    sf.in_valid = 1'b1;
    sf.in_row0  = small_row(0, 0);
    sf.in_row1  = small_row(0, 1);
    sf.in_row2  = small_row(0, 2);
    sf.in_row3  = small_row(0, 3);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (sf.mem_wen === 1'b1) begin
        s_addr.push_back(sf.mem_addr);
        s_data.push_back(sf.mem_wdata);
        if (sf.mem_addr == SMALL_AW'(SMALL_DEPTH - 1)) w7_cyc = cyc;
      end
      if (small_full === 1'b1 && full_cyc < 0) full_cyc = cyc;
      acc = (sf.in_ready === 1'b1);
      @(posedge clk);
      #1;
      if (acc) begin
        blk++;
        sf.in_row0 = small_row(blk, 0);
        sf.in_row1 = small_row(blk, 1);
        sf.in_row2 = small_row(blk, 2);
        sf.in_row3 = small_row(blk, 3);
      end
    end
    sf.in_valid = 1'b0;
    check("small_accepts", 64'(blk),           64'(2));
    check("small_writes",  64'(s_addr.size()), 64'(SMALL_DEPTH));
    for (int i = 0; i < s_addr.size() && i < SMALL_DEPTH; i++) begin
      check("small_addr", 64'(s_addr[i]), 64'(i));
      check("small_data", 64'(s_data[i]), 64'(small_row(i / 4, i % 4)));
    end
    check("small_full_edge", 64'(full_cyc), 64'(w7_cyc + 1));
    @(negedge clk);
    check("small_full",  64'(small_full),  64'(1));
    check("small_ready", 64'(sf.in_ready), 64'(0));
    check("small_count", 64'(small_count), 64'(2));
    check("small_wen",   64'(sf.mem_wen),  64'(0));
    @(posedge clk);
    #1;

    // Reset out of FULL, then the next block lands at word 0.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("unfull_full",  64'(small_full),  64'(0));
    check("unfull_ready", 64'(sf.in_ready), 64'(1));
    check("unfull_count", 64'(small_count), 64'(0));
    @(posedge clk);
    #1;
    sf.in_valid = 1'b1;
    sf.in_row0  = small_row(5, 0);
    sf.in_row1  = small_row(5, 1);
    sf.in_row2  = small_row(5, 2);
    sf.in_row3  = small_row(5, 3);
    @(posedge clk);
    #1;
    sf.in_valid = 1'b0;
    @(negedge clk);
    check("unfull_wen",   64'(sf.mem_wen),   64'(1));
    check("unfull_addr",  64'(sf.mem_addr),  64'(0));
    check("unfull_wdata", 64'(sf.mem_wdata), 64'(small_row(5, 0)));
    repeat (6) @(posedge clk);
    #1;

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
